// File: rtl/wb_window_bridge.sv
// Paged, width-converting Wishbone bridge: 16-bit upstream to a wide downstream
// slave. Provides a page register, a sticky status register, a one-word read buffer and a bus timeout.
module wb_window_bridge #(
  parameter int                       DN_DATA_WIDTH = 32,
  parameter int                       DN_ADDR_WIDTH = 30,
  parameter logic [DN_ADDR_WIDTH-1:0] BASE_WORD     = 30'h1000_0000,
  parameter int                       PAGE_BITS     = 8,
  parameter int                       TIMEOUT       = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                s_adr,
  input  logic [15:0]                s_dat_w,
  output logic [15:0]                s_dat_r,
  input  logic                       s_we,
  input  logic                       s_stb,
  input  logic                       s_cyc,
  output logic                       s_ack,
  output logic [DN_ADDR_WIDTH-1:0]   m_adr,
  output logic [DN_DATA_WIDTH-1:0]   m_dat_w,
  input  logic [DN_DATA_WIDTH-1:0]   m_dat_r,
  output logic [DN_DATA_WIDTH/8-1:0] m_sel,
  output logic                       m_we,
  output logic                       m_cyc,
  output logic                       m_stb,
  input  logic                       m_ack,
  input  logic                       m_err,
  output logic [2:0]                 m_cti,
  output logic [1:0]                 m_bte
);

  localparam int R    = DN_DATA_WIDTH / 16;
  localparam int L    = $clog2(R);
  localparam int LW   = (L > 0) ? L : 1;
  localparam int SELW = DN_DATA_WIDTH / 8;
  localparam int HW   = PAGE_BITS + 16;
  localparam int SW   = (HW > DN_ADDR_WIDTH) ? HW : DN_ADDR_WIDTH;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REG  = 3'd1;
  localparam logic [2:0] HIT  = 3'd2;
  localparam logic [2:0] BUS  = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]               state;
  logic [PAGE_BITS-1:0]     page;
  logic                     st_to, st_err;
  logic [7:0]               st_cnt;
  logic                     buf_valid;
  logic [DN_ADDR_WIDTH-1:0] buf_tag;
  logic [DN_DATA_WIDTH-1:0] buf_data;
  logic [LW-1:0]            lane_q;
  logic [15:0]              tmo_cnt;

  // Address translation: page-extended halfword address scaled to words, offset by the base.
  logic [HW-1:0]            h_adr;
  logic [SW-1:0]            sum_w;
  logic [DN_ADDR_WIDTH-1:0] adr_calc;
  logic [LW-1:0]            lane;
  logic [SELW-1:0]          wr_sel;

  assign h_adr    = {page, s_adr};
  assign sum_w    = SW'(BASE_WORD) + SW'(h_adr >> L);
  assign adr_calc = sum_w[DN_ADDR_WIDTH-1:0];

  generate
    if (L == 0) begin : g_one_lane
      assign lane = '0;
    end else begin : g_lanes
      assign lane = s_adr[LW-1:0];
    end
  endgenerate

  assign wr_sel = SELW'(2'b11) << {lane, 1'b0};

  logic is_page, is_status, req, st_clr, hit;
  logic tmo_hit, bus_err, bus_to, bus_ok;
  logic [15:0] page_rd, status_rd;

  assign is_page   = (s_adr == 16'hFFFF);
  assign is_status = (s_adr == 16'hFFFE);
  assign req       = (state == IDLE) && s_cyc && s_stb;
  assign st_clr    = req && is_status && !s_we;
  assign hit       = !s_we && buf_valid && (buf_tag == adr_calc);
  assign page_rd   = 16'(page);
  assign status_rd = {st_cnt, 6'b0, st_err, st_to};

  // m_err takes priority over m_ack; the timeout only fires with neither present.
  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));
  assign bus_err = (state == BUS) && m_err;
  assign bus_ok  = (state == BUS) && m_ack && !m_err;
  assign bus_to  = (state == BUS) && !m_ack && !m_err && tmo_hit;

  assign s_ack = (state == RESP);
  assign m_cti = 3'b000;
  assign m_bte = 2'b00;

  // A clear-on-read and a same-cycle failure: the failure survives the clear.
  logic [7:0] cnt_base, cnt_nxt;
  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    cnt_base = st_clr ? 8'd0 : st_cnt;
    cnt_nxt  = cnt_base;
    if ((bus_to || bus_err) && (cnt_base != 8'hFF)) cnt_nxt = cnt_base + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_to  <= 1'b0;
      st_err <= 1'b0;
      st_cnt <= 8'd0;
    end else begin
      st_to  <= (st_to  & ~st_clr) | bus_to;
      st_err <= (st_err & ~st_clr) | bus_err;
      st_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      page      <= '0;
      buf_valid <= 1'b0;
      lane_q    <= '0;
      tmo_cnt   <= '0;
      s_dat_r   <= '0;
      m_adr     <= '0;
      m_dat_w   <= '0;
      m_sel     <= '0;
      m_we      <= 1'b0;
      m_cyc     <= 1'b0;
      m_stb     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          lane_q <= lane;
          if (is_page || is_status) begin
            state <= REG;
            if (is_page && s_we) begin
              page      <= s_dat_w[PAGE_BITS-1:0];
              buf_valid <= 1'b0;
            end else if (!s_we) begin
              s_dat_r <= is_page ? page_rd : status_rd;
            end
          end else if (hit) begin
            state   <= HIT;
            s_dat_r <= buf_data[{lane, 4'b0} +: 16];
          end else begin
            state   <= BUS;
            m_cyc   <= 1'b1;
            m_stb   <= 1'b1;
            m_we    <= s_we;
            m_adr   <= adr_calc;
            m_sel   <= s_we ? wr_sel : '1;
            m_dat_w <= {R{s_dat_w}};
            tmo_cnt <= '0;
            if (s_we && buf_valid && (buf_tag == adr_calc)) buf_valid <= 1'b0;
          end
        end
        REG, HIT: state <= RESP;
        BUS: begin
          if (m_ack || m_err || tmo_hit) begin
            state <= RESP;
            m_cyc <= 1'b0;
            m_stb <= 1'b0;
            m_we  <= 1'b0;
            if (bus_err || bus_to) begin
              s_dat_r   <= 16'hDEAD;
              buf_valid <= 1'b0;
            end else if (!m_we) begin
              s_dat_r   <= m_dat_r[{lane_q, 4'b0} +: 16];
              buf_valid <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: buffer word and tag need no reset; buf_valid alone decides whether they are used.
  always_ff @(posedge clk) begin
    if (bus_ok && !m_we) begin
      buf_data <= m_dat_r;
      buf_tag  <= m_adr;
    end
  end

endmodule

// File: tb/tb_wb_window_bridge.sv
// Self-checking bench for wb_window_bridge: vector table plus hand-written
// timeout, error, saturation and reset sequences, with a behavioural downstream slave.
module tb_wb_window_bridge;

  localparam int DW  = 32;
  localparam int AW  = 30;
  localparam int TMO = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   s_adr = '0, s_dat_w = '0, s_dat_r;
  logic          s_we = 1'b0, s_stb = 1'b0, s_cyc = 1'b0, s_ack;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat_w, m_dat_r = '0;
  logic [3:0]    m_sel;
  logic          m_we, m_cyc, m_stb;
  logic          m_ack = 1'b0, m_err = 1'b0;
  logic [2:0]    m_cti;
  logic [1:0]    m_bte;

  always #5 clk = ~clk;

  wb_window_bridge #(
    .DN_DATA_WIDTH(DW), .DN_ADDR_WIDTH(AW), .BASE_WORD(30'h1000_0000),
    .PAGE_BITS(8), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r),
    .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc), .s_ack(s_ack),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_sel(m_sel),
    .m_we(m_we), .m_cyc(m_cyc), .m_stb(m_stb),
    .m_ack(m_ack), .m_err(m_err), .m_cti(m_cti), .m_bte(m_bte)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboards: upstream read data and downstream cycle attributes.
  typedef struct {
    logic [AW-1:0] adr;
    logic [3:0]    sel;
    logic [31:0]   dat;
    logic          we;
  } dn_t;
  dn_t         dn_q[$];
  logic [15:0] up_q[$];

  // Downstream slave: mode 0 acks after slv_dly cycles, 1 never answers, 2 raises ack and err together.
  int          slv_mode = 0;
  int          slv_dly = 0;
  logic [31:0] slv_rdata = '0;
  int          cyc_starts = 0;
  int          stb_cycles = 0;
  int          wcnt = 0;
  bit          in_cyc = 0;

  always @(negedge clk) begin : slave
    dn_t e;
    m_dat_r = slv_rdata;
    if (reset && m_cyc && m_stb) begin
      stb_cycles++;
      if (!in_cyc) begin
        in_cyc = 1;
        cyc_starts++;
        wcnt = 0;
        check("dn cycle expected", dn_q.size() > 0, 1);
        if (dn_q.size() > 0) begin
          e = dn_q.pop_front();
          check("dn m_adr", m_adr, e.adr);
          check("dn m_sel", m_sel, e.sel);
          check("dn m_we", m_we, e.we);
          if (e.we) check("dn m_dat_w", m_dat_w, e.dat);
        end
      end
      if (slv_mode == 1) begin
        m_ack = 0; m_err = 0;
      end else if (wcnt >= slv_dly) begin
        m_ack = 1; m_err = (slv_mode == 2);
      end else begin
        wcnt++;
      end
    end else begin
      in_cyc = 0; m_ack = 0; m_err = 0;
    end
  end

  task automatic xfer(input string nm, input logic we, input logic [15:0] adr,
                      input logic [15:0] wd, input logic chk, input logic [15:0] exp_rd,
                      input int exp_lat, input int exp_cyc,
                      input logic [AW-1:0] madr, input logic [3:0] sel);
    int  c0, lat;
    bit  got;
    dn_t e;
    c0 = cyc_starts;
    if (chk) up_q.push_back(exp_rd);
    if (exp_cyc != 0) begin
      e.adr = madr; e.sel = sel; e.dat = {2{wd}}; e.we = we;
      dn_q.push_back(e);
    end
    @(negedge clk);
    s_cyc = 1; s_stb = 1; s_we = we; s_adr = adr; s_dat_w = wd;
    got = 0; lat = 0;
    while (!got && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (s_ack) got = 1;
    end
    s_cyc = 0; s_stb = 0; s_we = 0;
    check({nm, " s_ack seen"}, got, 1);
    if (got) begin
      if (chk) check({nm, " s_dat_r"}, s_dat_r, up_q.pop_front());
      check({nm, " latency"}, lat, exp_lat);
      @(posedge clk); #1;
      check({nm, " s_ack one cycle"}, s_ack, 0);
    end else begin
      up_q = {};
    end
    check({nm, " m_cyc count"}, cyc_starts - c0, exp_cyc);
  endtask

  typedef struct {
    logic          we;
    logic [15:0]   adr;
    logic [15:0]   wd;
    int            dly;
    logic [31:0]   rdata;
    logic          chk;
    logic [15:0]   exp_rd;
    int            lat;
    int            cyc;
    logic [AW-1:0] madr;
    logic [3:0]    sel;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(logic we, logic [15:0] adr, logic [15:0] wd, int dly,
                              logic [31:0] rdata, logic chk, logic [15:0] exp_rd,
                              int cyc, logic [AW-1:0] madr, logic [3:0] sel);
    vec_t v;
    v.we = we; v.adr = adr; v.wd = wd; v.dly = dly; v.rdata = rdata;
    v.chk = chk; v.exp_rd = exp_rd; v.cyc = cyc; v.madr = madr; v.sel = sel;
    v.lat = (cyc != 0) ? dly + 2 : 2;
    return v;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    //        we  adr      wd       dly rdata         chk exp      cyc madr            sel
    vt.push_back(mk(0, 16'hFFFF, 16'h0000, 0, 32'h0,         1, 16'h0000, 0, '0,             4'h0));
    vt.push_back(mk(0, 16'hFFFE, 16'h0000, 0, 32'h0,         1, 16'h0000, 0, '0,             4'h0));
    vt.push_back(mk(1, 16'hFFFF, 16'h01A5, 0, 32'h0,         0, 16'h0000, 0, '0,             4'h0));
    vt.push_back(mk(0, 16'hFFFF, 16'h0000, 0, 32'h0,         1, 16'h00A5, 0, '0,             4'h0));
    vt.push_back(mk(1, 16'hFFFF, 16'h0002, 0, 32'h0,         0, 16'h0000, 0, '0,             4'h0));
    vt.push_back(mk(1, 16'h0003, 16'hBEEF, 0, 32'h0,         0, 16'h0000, 1, 30'h1001_0001, 4'b1100));
    vt.push_back(mk(0, 16'h0010, 16'h0000, 0, 32'h1234_5678, 1, 16'h5678, 1, 30'h1001_0008, 4'b1111));
    vt.push_back(mk(0, 16'h0011, 16'h0000, 0, 32'hFFFF_FFFF, 1, 16'h1234, 0, '0,             4'h0));
    vt.push_back(mk(1, 16'hFFFF, 16'h0002, 0, 32'h0,         0, 16'h0000, 0, '0,             4'h0));
    vt.push_back(mk(0, 16'h0011, 16'h0000, 3, 32'hCAFE_F00D, 1, 16'hCAFE, 1, 30'h1001_0008, 4'b1111));
    vt.push_back(mk(1, 16'h0010, 16'h1111, 0, 32'h0,         0, 16'h0000, 1, 30'h1001_0008, 4'b0011));
    vt.push_back(mk(0, 16'h0011, 16'h0000, 0, 32'hAAAA_5555, 1, 16'hAAAA, 1, 30'h1001_0008, 4'b1111));
    vt.push_back(mk(0, 16'h0012, 16'h0000, 0, 32'h0BAD_0001, 1, 16'h0001, 1, 30'h1001_0009, 4'b1111));
    vt.push_back(mk(0, 16'h0010, 16'h0000, 1, 32'h9999_8888, 1, 16'h8888, 1, 30'h1001_0008, 4'b1111));
    vt.push_back(mk(1, 16'hFFFF, 16'h00FF, 0, 32'h0,         0, 16'h0000, 0, '0,             4'h0));
    vt.push_back(mk(0, 16'hFFFD, 16'h0000, 0, 32'h7654_3210, 1, 16'h7654, 1, 30'h107F_FFFE, 4'b1111));
    vt.push_back(mk(0, 16'hFFFC, 16'h0000, 0, 32'h0,         1, 16'h3210, 0, '0,             4'h0));
    vt.push_back(mk(1, 16'hFFFA, 16'h5A5A, 0, 32'h0,         0, 16'h0000, 1, 30'h107F_FFFD, 4'b0011));
    vt.push_back(mk(0, 16'hFFFD, 16'h0000, 0, 32'h0,         1, 16'h7654, 0, '0,             4'h0));
    vt.push_back(mk(1, 16'hFFFE, 16'h1234, 0, 32'h0,         0, 16'h0000, 0, '0,             4'h0));
    vt.push_back(mk(0, 16'hFFFE, 16'h0000, 0, 32'h0,         1, 16'h0000, 0, '0,             4'h0));
    vt.push_back(mk(1, 16'hFFFF, 16'h0000, 0, 32'h0,         0, 16'h0000, 0, '0,             4'h0));

    // Reset state.
    repeat (5) @(posedge clk);
    #1;
    check("reset s_dat_r/s_ack/m_adr", {s_dat_r, s_ack, m_adr}, '0);
    check("reset m_dat_w/m_sel/ctl", {m_dat_w, m_sel, m_we, m_cyc, m_stb, m_cti, m_bte}, '0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vt[i]) begin
      slv_mode = 0; slv_dly = vt[i].dly; slv_rdata = vt[i].rdata;
      xfer($sformatf("vec%0d", i), vt[i].we, vt[i].adr, vt[i].wd, vt[i].chk, vt[i].exp_rd,
           vt[i].lat, vt[i].cyc, vt[i].madr, vt[i].sel);
    end
    slv_dly = 0;

    // Timeout: m_stb held exactly TMO cycles, buffer invalidated, STATUS clear-on-read.
    slv_rdata = 32'h0000_4444;
    xfer("tmo fill", 0, 16'h0030, 0, 1, 16'h4444, 2, 1, 30'h1000_0018, 4'hF);
    slv_mode = 1; s0 = stb_cycles;
    xfer("tmo read", 0, 16'h0040, 0, 1, 16'hDEAD, TMO + 1, 1, 30'h1000_0020, 4'hF);
    check("tmo m_stb cycles", stb_cycles - s0, TMO);
    slv_mode = 0;
    xfer("tmo status", 0, 16'hFFFE, 0, 1, 16'h0101, 2, 0, '0, 4'h0);
    xfer("tmo status clr", 0, 16'hFFFE, 0, 1, 16'h0000, 2, 0, '0, 4'h0);
    slv_rdata = 32'h6666_7777;
    xfer("tmo refetch", 0, 16'h0031, 0, 1, 16'h6666, 2, 1, 30'h1000_0018, 4'hF);

    // Simultaneous ack and err: err wins and invalidates the buffer.
    slv_rdata = 32'h1111_2222;
    xfer("err fill", 0, 16'h0050, 0, 1, 16'h2222, 2, 1, 30'h1000_0028, 4'hF);
    slv_mode = 2;
    xfer("err read", 0, 16'h0052, 0, 1, 16'hDEAD, 2, 1, 30'h1000_0029, 4'hF);
    slv_mode = 0;
    xfer("err status", 0, 16'hFFFE, 0, 1, 16'h0102, 2, 0, '0, 4'h0);
    slv_rdata = 32'h3333_4444;
    xfer("err refetch", 0, 16'h0051, 0, 1, 16'h3333, 2, 1, 30'h1000_0028, 4'hF);

    // Failure count saturates at 255.
    slv_mode = 2;
    for (int k = 0; k < 257; k++)
      xfer("sat err", 0, 16'h0060, 0, 1, 16'hDEAD, 2, 1, 30'h1000_0030, 4'hF);
    slv_mode = 0;
    xfer("sat status", 0, 16'hFFFE, 0, 1, 16'hFF02, 2, 0, '0, 4'h0);
    xfer("sat status clr", 0, 16'hFFFE, 0, 1, 16'h0000, 2, 0, '0, 4'h0);

    // Asynchronous reset in the middle of a downstream cycle.
    xfer("pre-reset page", 1, 16'hFFFF, 16'h0033, 0, 16'h0, 2, 0, '0, 4'h0);
    slv_mode = 1;
    begin
      dn_t e;
      e.adr = 30'h1019_8038; e.sel = 4'hF; e.dat = '0; e.we = 0;
      dn_q.push_back(e);
    end
    @(negedge clk);
    s_cyc = 1; s_stb = 1; s_we = 0; s_adr = 16'h0070;
    repeat (3) @(posedge clk);
    #1;
    check("mid-bus m_stb", m_stb, 1);
    reset = 1'b0;
    #1;
    check("reset drops m_cyc/m_stb", {m_cyc, m_stb, s_ack}, 3'b000);
    s_cyc = 0; s_stb = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    slv_mode = 0;
    xfer("post-reset page", 0, 16'hFFFF, 0, 1, 16'h0000, 2, 0, '0, 4'h0);
    xfer("post-reset status", 0, 16'hFFFE, 0, 1, 16'h0000, 2, 0, '0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_window_bridge.md
# wb_window_bridge

Paged, width-converting Wishbone bridge that sits between the 16-bit `gpmc_to_wishbone` master and the SoC's wide Wishbone slave port. It replaces the fixed `0x4000_0000 + addr` offset with a parametrised base plus a software-writable page register, so the full downstream space is reachable. It generates correct byte selects, and serves repeated halfword reads from a one-word read buffer. It also bounds every downstream cycle with a timeout, and reports failures through a sticky status register.

## Interface
- `DN_DATA_WIDTH`, 32 — downstream data width; one of 16, 32, 64. R = DN_DATA_WIDTH/16 lanes, L = log2(R).
- `DN_ADDR_WIDTH`, 30 — downstream word-address width.
- `BASE_WORD`, 30'h1000_0000 — downstream word base (byte 0x4000_0000 when R=2).
- `PAGE_BITS`, 8 — page register width (1..16).
- `TIMEOUT`, 255 — maximum cycles to wait for a downstream ack or error (2..65535).
- `clk` in 1 — sole clock.
- `reset` in 1 — asynchronous, active-low reset.
- `s_adr` in 16 — upstream halfword address.
- `s_dat_w` in 16 — upstream write data.
- `s_dat_r` out 16 — upstream read data, registered.
- `s_we`, `s_stb`, `s_cyc` in 1 each — upstream classic Wishbone controls.
- `s_ack` out 1 — upstream acknowledge, one-cycle pulse.
- `m_adr` out DN_ADDR_WIDTH — downstream word address.
- `m_dat_w` out DN_DATA_WIDTH — downstream write data.
- `m_dat_r` in DN_DATA_WIDTH — downstream read data.
- `m_sel` out DN_DATA_WIDTH/8 — downstream byte selects.
- `m_we`, `m_cyc`, `m_stb` out 1 each — downstream classic Wishbone controls.
- `m_ack`, `m_err` in 1 each — downstream acknowledge and error.
- `m_cti` out 3 — tied to 3'b000.
- `m_bte` out 2 — tied to 2'b00.

## Operation
- Upstream address map, in every page:
  - `0xFFFF` is PAGE: R/W, low PAGE_BITS bits used, upper bits read as 0.
  - `0xFFFE` is STATUS: read-only, clear-on-read. Bit0 = sticky timeout, bit1 = sticky m_err, bits[15:8] = saturating failure count (stops at 255).
  - All other addresses are windowed downstream. The `0xFFFE`/`0xFFFF` slots of each page are not reachable downstream.
- Address mapping:
  - h = {PAGE, s_adr} (PAGE_BITS+16 bits).
  - m_adr = (BASE_WORD + (h >> L)) mod 2^DN_ADDR_WIDTH.
  - lane = s_adr[L-1:0] (0 when R=1).
- Byte selects and data:
  - m_sel = 2'b11 << (2·lane).
  - m_dat_w = s_dat_w replicated R times.
  - Read data returned = m_dat_r[16·lane +: 16].
- Read buffer: holds one word, its m_adr tag, and a valid bit.
  - Filled by every successful downstream read; reads always fetch the full word with all-ones m_sel.
  - Invalidated by: a PAGE write, any downstream write whose m_adr equals the tag, a timeout, or an m_err.
- FSM states: IDLE, REG, HIT, BUS, RESP.
  - IDLE → REG when s_cyc&s_stb and the address is PAGE or STATUS.
  - IDLE → HIT when the transfer is a read, the buffer is valid, and the tag equals the computed m_adr.
  - IDLE → BUS otherwise. On entry, m_cyc/m_stb/m_we/m_adr/m_sel/m_dat_w are registered and the timeout counter is cleared.
  - REG → RESP and HIT → RESP, each after one cycle.
  - BUS → RESP on m_ack, m_err, or timeout (counter reaches TIMEOUT-1 with neither m_ack nor m_err seen). m_cyc/m_stb are deasserted in the same edge.
  - RESP: s_ack = 1 for one cycle, then → IDLE.
- Failure response: s_dat_r = 16'hDEAD, write discarded, matching STATUS bit set, count incremented.
- Simultaneous m_ack and m_err: m_err wins.
- Upstream master must deassert s_stb the cycle after s_ack. A still-high s_stb in IDLE starts a new transfer.
- A STATUS read that coincides with a failure: the read returns the old value, and the new failure is recorded after the clear.

## Timing
- Reset (asynchronous, `reset`=0): all outputs 0, PAGE=0, STATUS=0, buffer invalid, FSM=IDLE. A reset mid-BUS drops m_cyc/m_stb immediately.
- Latencies, from the edge that samples s_stb:
  - Register access and buffer hit: s_ack high after 2 edges.
  - Downstream access: m_stb high after 1 edge. s_ack high 1 edge after the edge sampling m_ack/m_err.
  - Timeout: m_stb held for exactly TIMEOUT cycles, then dropped and s_ack pulsed.
- s_dat_r is valid in the s_ack cycle and holds until the next transfer.

## Test plan
- Reset values: hold `reset`=0 for 5 cycles → all outputs 0. Reads of PAGE and STATUS after release → 0x0000 each.
- Page register: write 0x01A5 to 0xFFFF with PAGE_BITS=8 → readback 0x00A5.
- Mapped write with R=2, PAGE=0x02: write 0xBEEF to s_adr 0x0003 → m_adr = BASE_WORD+0x10001, m_sel = 4'b1100, m_dat_w = 0xBEEFBEEF, single s_ack.
- Read buffer: read 0x0010 with downstream returning 0x12345678 → s_dat_r = 0x5678. Then read 0x0011 → s_dat_r = 0x1234 with no m_cyc. Write PAGE, re-read 0x0011 → m_cyc asserted again.
- Timeout: slave never acks, TIMEOUT=10 → m_stb high exactly 10 cycles, s_dat_r = 0xDEAD. STATUS reads 0x0101, then 0x0000 on the next read.
- Error: m_err and m_ack asserted together → s_dat_r = 0xDEAD, STATUS = 0x0102, buffer invalid.
